// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared FIR definitions: default widths and driver state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int c_DEF_TAP_SIZE    = 3;
    localparam int c_DEF_NBR_OF_TAPS = 3;
    localparam int c_DEF_X_N_SIZE    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STREAM = 2'b01,
        ST_LOAD   = 2'b10,
        ST_GAP    = 2'b11
    } state_e;

    // Index width that stays legal (>= 1 bit) even for a single-entry bank.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_stream_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_stream_driver_if
// Description : Host word handshake plus FIR stimulus outputs of the driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_stream_driver_if
    import fir_pkg::*;
#(
    parameter int X_N_SIZE = c_DEF_X_N_SIZE
);

    logic [X_N_SIZE-1:0] in_data;
    logic                in_valid;
    logic                in_is_coeff;
    logic                in_ready;
    logic [X_N_SIZE-1:0] x_n;
    logic                s_set_coeffs;
    logic                s_axis_fir_tvalid;
    logic                busy;

    modport master (
        output in_data, in_valid, in_is_coeff,
        input  in_ready, x_n, s_set_coeffs, s_axis_fir_tvalid, busy
    );

    modport slave (
        input  in_data, in_valid, in_is_coeff,
        output in_ready, x_n, s_set_coeffs, s_axis_fir_tvalid, busy
    );

endinterface
`default_nettype wire

// File: rtl/fir_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_sample_fifo
// Description : Small synchronous sample FIFO with a registered-free head view.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [WIDTH-1:0]      o_head
);

    localparam int c_AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_head    = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_stream_driver.sv
`default_nettype none
// ============================================================================
// Module      : fir_stream_driver
// Description : Host-to-FIR front end: coefficient load bursts and sample stream.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_stream_driver
    import fir_pkg::*;
#(
    parameter int TAP_SIZE    = c_DEF_TAP_SIZE,
    parameter int NBR_OF_TAPS = c_DEF_NBR_OF_TAPS,
    parameter int X_N_SIZE    = c_DEF_X_N_SIZE,
    parameter int FIFO_DEPTH  = 4
) (
    input wire logic          clk,
    input wire logic          reset,
    fir_stream_driver_if.slave bus
);

    localparam int c_IDX_W = clog2_min1(NBR_OF_TAPS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NBR_OF_TAPS - 1);

    // Coefficient bank
    logic [TAP_SIZE-1:0] r_coef [NBR_OF_TAPS];
    logic [c_IDX_W-1:0]  r_widx;
    logic                r_load_pending;
    logic                w_coef_ready;
    logic                w_coef_acc;

    // FSM and registered FIR outputs
    state_e              r_state;
    state_e              w_state_next;
    logic [c_IDX_W-1:0]  r_lidx;
    logic [c_IDX_W-1:0]  w_lidx_next;
    logic [c_IDX_W-1:0]  w_rd_idx;
    logic [TAP_SIZE-1:0] w_coef_sel;
    logic                w_load_done;
    logic [X_N_SIZE-1:0] r_x_n;
    logic [X_N_SIZE-1:0] w_x_n_next;
    logic                r_set_coeffs;
    logic                w_set_coeffs_next;
    logic                r_tvalid;
    logic                w_tvalid_next;
    logic                r_busy;

    // Sample FIFO
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [X_N_SIZE-1:0] w_fifo_head;

    assign w_coef_ready = !r_load_pending && (r_state != ST_LOAD);
    assign w_coef_acc   = bus.in_valid && bus.in_is_coeff && w_coef_ready;
    assign w_push       = bus.in_valid && !bus.in_is_coeff && !w_fifo_full;

    assign bus.in_ready          = bus.in_is_coeff ? w_coef_ready : !w_fifo_full;
    assign bus.x_n               = r_x_n;
    assign bus.s_set_coeffs      = r_set_coeffs;
    assign bus.s_axis_fir_tvalid = r_tvalid;
    assign bus.busy              = r_busy;

    fir_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (X_N_SIZE)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (bus.in_data),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_fifo_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_widx         <= '0;
            r_load_pending <= 1'b0;
            for (int i = 0; i < NBR_OF_TAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else begin
            if (w_coef_acc) begin
                r_coef[r_widx] <= bus.in_data[TAP_SIZE-1:0];
                if (r_widx == c_LAST_IDX) begin
                    r_widx         <= '0;
                    r_load_pending <= 1'b1;
                end else begin
                    r_widx <= r_widx + 1'b1;
                end
            end
            if (w_load_done) begin
                r_load_pending <= 1'b0;
            end
        end
    end

    // Burst replays the highest index first so the FIR shift register ends
    // with taps[i] = coef[i].
    assign w_rd_idx   = c_LAST_IDX - w_lidx_next;
    assign w_coef_sel = r_coef[w_rd_idx];

    always_comb begin
        w_state_next      = r_state;
        w_lidx_next       = r_lidx;
        w_load_done       = 1'b0;
        w_pop             = 1'b0;
        w_x_n_next        = '0;
        w_set_coeffs_next = 1'b0;
        w_tvalid_next     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_load_pending) begin
                    w_state_next = ST_LOAD;
                    w_lidx_next  = '0;
                end else if (!w_fifo_empty) begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (r_load_pending || w_fifo_empty) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (r_lidx == c_LAST_IDX) begin
                    w_state_next = ST_GAP;
                    w_load_done  = 1'b1;
                end else begin
                    w_lidx_next = r_lidx + 1'b1;
                end
            end
            ST_GAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they follow the state being entered.
        case (w_state_next)
            ST_STREAM: begin
                w_pop         = 1'b1;
                w_x_n_next    = w_fifo_head;
                w_tvalid_next = 1'b1;
            end
            ST_LOAD: begin
                w_x_n_next        = X_N_SIZE'($signed(w_coef_sel));
                w_set_coeffs_next = 1'b1;
            end
            default: begin
                w_x_n_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_lidx       <= '0;
            r_x_n        <= '0;
            r_set_coeffs <= 1'b0;
            r_tvalid     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_lidx       <= w_lidx_next;
            r_x_n        <= w_x_n_next;
            r_set_coeffs <= w_set_coeffs_next;
            r_tvalid     <= w_tvalid_next;
            r_busy       <= (w_state_next != ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_stream_driver
// Description : Directed, table-driven bench for the FIR stream driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_stream_driver;

    typedef struct packed {
        logic       v;
        logic       c;
        logic [7:0] d;
        logic [7:0] x;
        logic       sc;
        logic       tv;
        logic       b;
        logic       rdy;
    } vec_t;

    logic       clk;
    logic       reset;
    int         n_checks;
    int         n_pass;
    vec_t       tbl [$];
    logic [7:0] cap_q [$];
    logic       cap_en;
    int         seg_a_end;

    fir_stream_driver_if #(.X_N_SIZE(8)) bus ();

    fir_stream_driver #(
        .TAP_SIZE    (3),
        .NBR_OF_TAPS (3),
        .X_N_SIZE    (8),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cap_en && bus.s_axis_fir_tvalid) begin
            cap_q.push_back(bus.x_n);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic c, input logic [7:0] d);
        bus.in_valid    = v;
        bus.in_is_coeff = c;
        bus.in_data     = d;
    endtask

    task automatic add(input logic v, input logic c, input logic [7:0] d,
                       input logic [7:0] x, input logic sc, input logic tv,
                       input logic b, input logic rdy);
        vec_t t;
        t.v = v; t.c = c; t.d = d; t.x = x;
        t.sc = sc; t.tv = tv; t.b = b; t.rdy = rdy;
        tbl.push_back(t);
    endtask

    task automatic chk_outs(input string nm, input logic [7:0] x, input logic sc,
                            input logic tv, input logic b);
        chk({nm, "_x"},    32'(bus.x_n), 32'(x));
        chk({nm, "_sc"},   32'(bus.s_set_coeffs), 32'(sc));
        chk({nm, "_tv"},   32'(bus.s_axis_fir_tvalid), 32'(tv));
        chk({nm, "_busy"}, 32'(bus.busy), 32'(b));
    endtask

    // Each row: check outputs after the last edge, drive inputs, check in_ready.
    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            chk_outs($sformatf("row%0d", i), tbl[i].x, tbl[i].sc, tbl[i].tv, tbl[i].b);
            drive(tbl[i].v, tbl[i].c, tbl[i].d);
            #1;
            chk($sformatf("row%0d_rdy", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cap_en   = 1'b0;
        reset    = 1'b1;
        drive(1'b0, 1'b0, 8'h00);

        // Coefficient load 7,0,7 -> FF,00,FF burst then GAP
        add(1,1,8'h07, 8'h00,0,0,0, 1);
        add(1,1,8'h00, 8'h00,0,0,0, 1);
        add(1,1,8'h07, 8'h00,0,0,0, 1);
        add(0,1,8'h00, 8'h00,0,0,0, 0);
        add(0,1,8'h00, 8'hFF,1,0,1, 0);
        add(0,1,8'h00, 8'h00,1,0,1, 0);
        add(0,1,8'h00, 8'hFF,1,0,1, 0);
        add(0,1,8'h00, 8'h00,0,0,1, 1);
        add(0,1,8'h00, 8'h00,0,0,0, 1);
        // Back-to-back samples 01,02,7F,80
        add(1,0,8'h01, 8'h00,0,0,0, 1);
        add(1,0,8'h02, 8'h00,0,0,0, 1);
        add(1,0,8'h7F, 8'h01,0,1,1, 1);
        add(1,0,8'h80, 8'h02,0,1,1, 1);
        add(0,0,8'h00, 8'h7F,0,1,1, 1);
        add(0,0,8'h00, 8'h80,0,1,1, 1);
        add(0,0,8'h00, 8'h00,0,0,0, 1);
        seg_a_end = tbl.size();
        // Load requested while a backlog streams
        add(1,1,8'h01, 8'h00,0,0,0, 1);
        add(1,1,8'h02, 8'h00,0,0,0, 1);
        add(1,1,8'h03, 8'h00,0,0,0, 1);
        add(1,0,8'h41, 8'h00,0,0,0, 1);
        add(1,0,8'h42, 8'h03,1,0,1, 1);
        add(1,0,8'h43, 8'h02,1,0,1, 1);
        add(1,0,8'h44, 8'h01,1,0,1, 1);
        add(1,1,8'h04, 8'h00,0,0,1, 1);
        add(1,1,8'h05, 8'h00,0,0,0, 1);
        add(1,1,8'h06, 8'h41,0,1,1, 1);
        add(0,1,8'h00, 8'h42,0,1,1, 0);
        add(0,1,8'h00, 8'h00,0,0,0, 0);
        add(0,1,8'h00, 8'hFE,1,0,1, 0);
        add(0,1,8'h00, 8'hFD,1,0,1, 0);
        add(0,1,8'h00, 8'hFC,1,0,1, 0);
        add(0,0,8'h00, 8'h00,0,0,1, 1);
        add(0,0,8'h00, 8'h00,0,0,0, 1);
        add(0,0,8'h00, 8'h43,0,1,1, 1);
        add(0,0,8'h00, 8'h44,0,1,1, 1);
        add(0,0,8'h00, 8'h00,0,0,0, 1);

        // Reset and quiet idle
        step();
        chk_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_outs($sformatf("idle%0d", i), 8'h00, 1'b0, 1'b0, 1'b0);
        end

        run_rows(0, seg_a_end);

        // Five samples while loading: fifth waits for the first pop
        cap_q.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 8'h01);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'(8'h11 + i));
            #1;
            chk($sformatf("fill%0d_rdy", i), 32'(bus.in_ready), 32'd1);
            step();
        end
        drive(1'b1, 1'b0, 8'h15);
        #1;
        chk("full_gap_rdy", 32'(bus.in_ready), 32'd0);
        step();
        #1;
        chk("full_idle_rdy", 32'(bus.in_ready), 32'd0);
        step();
        #1;
        chk("first_pop_rdy", 32'(bus.in_ready), 32'd1);
        chk("first_pop_x", 32'(bus.x_n), 32'h11);
        step();
        drive(1'b0, 1'b0, 8'h00);
        repeat (8) step();
        cap_en = 1'b0;
        chk("five_count", 32'(cap_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("five_order%0d", i),
                (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hFFFF_FFFF, 32'(8'h11 + i));
        end

        run_rows(seg_a_end, tbl.size());

        // Reset on the second LOAD cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 8'h07);
            step();
        end
        drive(1'b0, 1'b1, 8'h00);
        step();
        chk("rl1_x", 32'(bus.x_n), 32'hFF);
        step();
        chk("rl2_sc", 32'(bus.s_set_coeffs), 32'd1);
        reset = 1'b1;
        step();
        chk_outs("rl_after", 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(1'b1, 1'b0, 8'h55);
        #1;
        chk("rl_samp_rdy", 32'(bus.in_ready), 32'd1);
        step();
        drive(1'b0, 1'b0, 8'h00);
        chk_outs("rl_samp_wait", 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        chk_outs("rl_samp_out", 8'h55, 1'b0, 1'b1, 1'b1);
        step();
        chk_outs("rl_samp_end", 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h02);
        step();
        drive(1'b1, 1'b1, 8'h00);
        step();
        step();
        drive(1'b0, 1'b1, 8'h00);
        step();
        chk_outs("rl_reload0", 8'h00, 1'b1, 1'b0, 1'b1);
        step();
        chk_outs("rl_reload1", 8'h00, 1'b1, 1'b0, 1'b1);
        step();
        chk_outs("rl_reload2", 8'h02, 1'b1, 1'b0, 1'b1);
        step();
        chk_outs("rl_gap", 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        chk_outs("rl_done", 8'h00, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
